// File: rtl/mawg_capture.sv
// rtl/mawg_capture.sv - descriptor-driven waveform capture engine feeding the wave RAM write port
//
// Purpose: runs a table of {skip, length, offset} descriptors on a kick. For each
// descriptor it drops `skip` valid input samples, then writes `length` valid
// samples into the wave RAM starting at `offset`.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   ctrl_addr/data/we      descriptor table write port ({skip, length, offset}, offset in LSBs)
//   kick, abort            start a run / stop the current run
//   ctrl_length            number of descriptors to run (1..2**CTRL_DEPTH)
//   busy                   run in progress (or kick being presented)
//   din_valid, din         input sample stream
//   wave_waddr/wdata/we    wave RAM write port, registered
//   done                   one-cycle pulse on normal completion
module mawg_capture #(
  parameter int CTRL_DEPTH = 4,
  parameter int WAVE_DEPTH = 16,
  parameter int WAVE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CTRL_DEPTH-1:0]          ctrl_addr,
  input  logic [2*WAVE_DEPTH+16-1:0]     ctrl_data,
  input  logic                           ctrl_we,
  input  logic                           kick,
  input  logic                           abort,
  input  logic [CTRL_DEPTH:0]            ctrl_length,
  output logic                           busy,
  input  logic                           din_valid,
  input  logic [WAVE_WIDTH-1:0]          din,
  output logic [WAVE_DEPTH-1:0]          wave_waddr,
  output logic [WAVE_WIDTH-1:0]          wave_wdata,
  output logic                           wave_we,
  output logic                           done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;
  localparam logic [1:0] ST_CAPT = 2'd3;

  localparam logic [WAVE_DEPTH-1:0] W_ONE = 1;
  localparam logic [15:0]           S_ONE = 1;
  localparam logic [CTRL_DEPTH-1:0] R_ONE = 1;
  localparam logic [CTRL_DEPTH:0]   L_ONE = 1;

  logic [2*WAVE_DEPTH+16-1:0] table_q [2**CTRL_DEPTH];

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic [CTRL_DEPTH-1:0] raddr_q, raddr_d;
  logic [CTRL_DEPTH:0]   len_q, len_d;
  logic [WAVE_DEPTH-1:0] wr_addr_q, wr_addr_d;
  logic [WAVE_DEPTH-1:0] cap_cnt_q, cap_cnt_d;
  logic [15:0]           skip_cnt_q, skip_cnt_d;
  logic                  we_q, we_d;
  logic [WAVE_DEPTH-1:0] waddr_q, waddr_d;
  logic [WAVE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;

  logic [WAVE_DEPTH-1:0] ent_off;
  logic [WAVE_DEPTH-1:0] ent_len;
  logic [15:0]           ent_skip;
  logic                  end_entry;
  logic                  more_entries;

  // Table is deliberately not reset so descriptors survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (ctrl_we) begin
      table_q[ctrl_addr] <= ctrl_data;
    end
  end

  // Combinational read: a write to a not-yet-loaded entry is seen by this run.
  assign ent_off  = table_q[raddr_q][WAVE_DEPTH-1:0];
  assign ent_len  = table_q[raddr_q][2*WAVE_DEPTH-1:WAVE_DEPTH];
  assign ent_skip = table_q[raddr_q][2*WAVE_DEPTH+15:2*WAVE_DEPTH];

  assign more_entries = ({1'b0, raddr_q} + L_ONE) < len_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    raddr_d    = raddr_q;
    len_d      = len_q;
    wr_addr_d  = wr_addr_q;
    cap_cnt_d  = cap_cnt_q;
    skip_cnt_d = skip_cnt_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    end_entry  = 1'b0;

    if (state_q == ST_IDLE) begin
      busy_d = 1'b0;
      if (kick && (ctrl_length != '0)) begin
        len_d   = ctrl_length;
        raddr_d = '0;
        busy_d  = 1'b1;
        state_d = ST_LOAD;
      end
    end else if (abort) begin
      // Abort wins over din_valid: nothing new is registered this cycle.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          wr_addr_d  = ent_off;
          cap_cnt_d  = ent_len;
          skip_cnt_d = ent_skip;
          if (ent_len == '0) begin
            end_entry = 1'b1;
          end else if (ent_skip != '0) begin
            state_d = ST_SKIP;
          end else begin
            state_d = ST_CAPT;
          end
        end
        ST_SKIP: begin
          if (din_valid) begin
            skip_cnt_d = skip_cnt_q - S_ONE;
            if (skip_cnt_q == S_ONE) begin
              state_d = ST_CAPT;
            end
          end
        end
        default: begin
          if (din_valid) begin
            we_d      = 1'b1;
            waddr_d   = wr_addr_q;
            wdata_d   = din;
            wr_addr_d = wr_addr_q + W_ONE;
            cap_cnt_d = cap_cnt_q - W_ONE;
            if (cap_cnt_q == W_ONE) begin
              end_entry = 1'b1;
            end
          end
        end
      endcase

      if (end_entry) begin
        if (more_entries) begin
          raddr_d = raddr_q + R_ONE;
          state_d = ST_LOAD;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b1;
      raddr_q    <= '0;
      len_q      <= '0;
      wr_addr_q  <= '0;
      cap_cnt_q  <= '0;
      skip_cnt_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      raddr_q    <= raddr_d;
      len_q      <= len_d;
      wr_addr_q  <= wr_addr_d;
      cap_cnt_q  <= cap_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  assign busy       = busy_q | kick;
  assign wave_we    = we_q;
  assign wave_waddr = waddr_q;
  assign wave_wdata = wdata_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mawg_capture.sv
// tb/tb_mawg_capture.sv - self-checking bench for mawg_capture
module tb_mawg_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctrl_addr;
  logic [47:0] ctrl_data;
  logic        ctrl_we;
  logic        kick;
  logic        abort;
  logic [4:0]  ctrl_length;
  logic        busy;
  logic        din_valid;
  logic [15:0] din;
  logic [15:0] wave_waddr;
  logic [15:0] wave_wdata;
  logic        wave_we;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  mawg_capture dut (
    .clk(clk), .reset(reset),
    .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data), .ctrl_we(ctrl_we),
    .kick(kick), .abort(abort), .ctrl_length(ctrl_length), .busy(busy),
    .din_valid(din_valid), .din(din),
    .wave_waddr(wave_waddr), .wave_wdata(wave_wdata), .wave_we(wave_we),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is flattened into a queue of steps. A LOAD step is consumed every
  // cycle; SKIP/CAPT steps are consumed only by a valid sample.
  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_SKIP = 2'd1;
  localparam logic [1:0] K_CAPT = 2'd2;
  typedef struct packed { logic [1:0] kind; logic [15:0] addr; } tok_t;

  tok_t        mq[$];
  logic [47:0] mtbl [16];
  logic        m_run = 1'b0;
  logic        exp_busy_r = 1'b1;
  logic        exp_we = 1'b0;
  logic [15:0] exp_waddr = '0;
  logic [15:0] exp_wdata = '0;
  logic        exp_done = 1'b0;
  logic        started = 1'b0;

  logic [31:0] wlog[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    tok_t t;
    started <= 1'b1;
    if (ctrl_we) mtbl[ctrl_addr] = ctrl_data;
    exp_we   = 1'b0;
    exp_done = 1'b0;
    if (reset) begin
      mq.delete();
      m_run      = 1'b0;
      exp_busy_r = 1'b1;
      exp_waddr  = '0;
      exp_wdata  = '0;
    end else if (m_run) begin
      if (abort) begin
        mq.delete();
        m_run      = 1'b0;
        exp_busy_r = 1'b0;
      end else begin
        t = mq[0];
        if (t.kind == K_LOAD || din_valid) begin
          void'(mq.pop_front());
          if (t.kind == K_CAPT) begin
            exp_we    = 1'b1;
            exp_waddr = t.addr;
            exp_wdata = din;
          end
          if (mq.size() == 0) begin
            exp_done   = 1'b1;
            m_run      = 1'b0;
            exp_busy_r = 1'b0;
          end
        end
      end
    end else begin
      exp_busy_r = 1'b0;
      if (kick && ctrl_length != 0) begin
        for (int e = 0; e < int'(ctrl_length); e++) begin
          mq.push_back('{K_LOAD, 16'h0});
          for (int s = 0; s < int'(mtbl[e][47:32]); s++) mq.push_back('{K_SKIP, 16'h0});
          for (int c = 0; c < int'(mtbl[e][31:16]); c++)
            mq.push_back('{K_CAPT, 16'(mtbl[e][15:0] + c)});
        end
        m_run      = 1'b1;
        exp_busy_r = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("wave_we", {31'b0, wave_we}, {31'b0, exp_we});
      if (exp_we) begin
        chk("wave_waddr", {16'b0, wave_waddr}, {16'b0, exp_waddr});
        chk("wave_wdata", {16'b0, wave_wdata}, {16'b0, exp_wdata});
      end
      chk("done", {31'b0, done}, {31'b0, exp_done});
      chk("busy", {31'b0, busy}, {31'b0, exp_busy_r | kick});
      if (wave_we) wlog.push_back({wave_waddr, wave_wdata});
      if (done) done_cnt++;
    end
  end

  task automatic step(input logic k, input logic a, input logic v, input logic [15:0] d);
    kick = k; abort = a; din_valid = v; din = d;
    @(posedge clk); #1;
  endtask

  task automatic wr_desc(input logic [3:0] idx, input logic [15:0] sk,
                         input logic [15:0] ln, input logic [15:0] off);
    ctrl_we = 1'b1; ctrl_addr = idx; ctrl_data = {sk, ln, off};
    step(0, 0, 0, 0);
    ctrl_we = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [31:0] exp[$], input int exp_done_cnt);
    chk({name, "_nwrites"}, wlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wlog.size(); i++)
      chk({name, "_write"}, wlog[i], exp[i]);
    chk({name, "_done_cnt"}, done_cnt, exp_done_cnt);
    wlog.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [31:0] e[$];
    reset = 1'b1; ctrl_addr = '0; ctrl_data = '0; ctrl_we = 1'b0;
    kick = 1'b0; abort = 1'b0; ctrl_length = 5'd1; din_valid = 1'b0; din = '0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_waddr", {16'b0, wave_waddr}, 32'h0);
    chk("reset_wdata", {16'b0, wave_wdata}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // Single entry
    wr_desc(0, 0, 4, 16'h0010);
    ctrl_length = 5'd1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(i));
    chk("single_done_now", {31'b0, done}, 32'h1);
    chk("single_busy_low", {31'b0, busy}, 32'h0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    e = '{32'h0010_0001, 32'h0011_0002, 32'h0012_0003, 32'h0013_0004};
    check_log("single", e, 1);

    // Skip with gaps
    wr_desc(0, 2, 3, 16'h0000);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 10; i <= 14; i++) begin
      step(0, 0, 1, 16'(i));
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    e = '{32'h0000_000C, 32'h0001_000D, 32'h0002_000E};
    check_log("skip", e, 1);

    // Multi-entry with an empty entry, samples present during LOAD
    wr_desc(0, 0, 2, 16'h0020);
    wr_desc(1, 0, 0, 16'h0030);
    wr_desc(2, 0, 2, 16'h0040);
    ctrl_length = 5'd3;
    step(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 16'(i));
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    e = '{32'h0020_0002, 32'h0021_0003, 32'h0040_0006, 32'h0041_0007};
    check_log("multi", e, 1);

    // Address wrap
    wr_desc(0, 0, 3, 16'hFFFF);
    ctrl_length = 5'd1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'h000A); step(0, 0, 1, 16'h000B); step(0, 0, 1, 16'h000C);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    e = '{32'hFFFF_000A, 32'h0000_000B, 32'h0001_000C};
    check_log("wrap", e, 1);

    // Abort after 2nd of 8 samples; kick while busy is ignored
    wr_desc(0, 0, 8, 16'h0050);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'd1);
    step(1, 0, 1, 16'd2);
    step(0, 1, 1, 16'd3);
    for (int i = 4; i <= 8; i++) step(0, 0, 1, 16'(i));
    step(0, 0, 0, 0);
    e = '{32'h0050_0001, 32'h0051_0002};
    check_log("abort", e, 0);

    // kick with ctrl_length = 0
    ctrl_length = 5'd0;
    step(1, 0, 1, 16'h0077);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0077);
    step(0, 0, 0, 0);
    e = '{};
    check_log("zero_len", e, 0);

    // Reset mid-CAPT, then rerun from the preserved table
    wr_desc(0, 0, 4, 16'h0010);
    ctrl_length = 5'd1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'd1);
    step(0, 0, 1, 16'd2);
    reset = 1'b1;
    step(0, 0, 1, 16'd3);
    reset = 1'b0;
    chk("post_reset_busy", {31'b0, busy}, 32'h1);
    chk("post_reset_we", {31'b0, wave_we}, 32'h0);
    step(0, 0, 1, 16'd4);
    chk("post_reset_busy2", {31'b0, busy}, 32'h0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 5; i <= 8; i++) step(0, 0, 1, 16'(i));
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    e = '{32'h0010_0001, 32'h0011_0002, 32'h0010_0005, 32'h0011_0006,
          32'h0012_0007, 32'h0013_0008};
    check_log("reset_rerun", e, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
